// File: rtl/score_keeper.sv
// Game score unit: N-digit packed-BCD score advanced by a divided time tick and bonus events.
// Latency: score and high score update one edge after tick/bonus/gameover; no input backpressure.
module score_keeper #(
    parameter int DIGITS   = 6,
    parameter int TICK_DIV = 50000000,
    parameter int BLANK_LZ = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  gameover,
    input  logic                  pause,
    input  logic                  bonus_valid,
    input  logic [3:0]            bonus_amt,
    input  logic                  show_hi,
    output logic [4*DIGITS-1:0]   score_bcd,
    output logic [4*DIGITS-1:0]   hiscore_bcd,
    output logic                  running,
    output logic                  new_hiscore,
    output logic                  overflow,
    output logic [7*DIGITS-1:0]   seg
);
    localparam int DW = $clog2(TICK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);
    localparam logic [4*DIGITS-1:0] ALL_NINES = {DIGITS{4'h9}};

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSED, S_OVER} state_t;

    state_t                r_state;
    logic [DW-1:0]         r_div;
    logic [4*DIGITS-1:0]   r_score;
    logic [4*DIGITS-1:0]   r_hiscore;
    logic                  r_new_hi;
    logic                  r_ovf;

    logic                  w_tick;
    logic [4:0]            w_addend;
    logic [4*DIGITS-1:0]   w_sum;
    logic                  w_carry_out;
    logic [4:0]            w_dsum;
    logic [1:0]            w_c;

    assign w_tick   = (r_div == DIV_LAST);
    assign w_addend = {4'd0, w_tick} + (bonus_valid ? {1'b0, bonus_amt} : 5'd0);

    // Digit 0 sees up to 9+16, so its carry can be 2; every higher digit carries at most 1.
    always_comb begin
        w_sum  = '0;
        w_c    = 2'd0;
        w_dsum = 5'd0;
        for (int i = 0; i < DIGITS; i++) begin
            w_dsum = {1'b0, r_score[4*i +: 4]} + ((i == 0) ? w_addend : {3'd0, w_c});
            if (w_dsum >= 5'd20) begin
                w_sum[4*i +: 4] = 4'(w_dsum - 5'd20);
                w_c = 2'd2;
            end else if (w_dsum >= 5'd10) begin
                w_sum[4*i +: 4] = 4'(w_dsum - 5'd10);
                w_c = 2'd1;
            end else begin
                w_sum[4*i +: 4] = w_dsum[3:0];
                w_c = 2'd0;
            end
        end
        w_carry_out = (w_c != 2'd0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_div     <= '0;
            r_score   <= '0;
            r_hiscore <= '0;
            r_new_hi  <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_OVER: begin
                    if (start) begin
                        r_state  <= S_RUN;
                        r_score  <= '0;
                        r_div    <= '0;
                        r_ovf    <= 1'b0;
                        r_new_hi <= 1'b0;
                    end
                end
                S_RUN, S_PAUSED: begin
                    if (gameover) begin
                        r_state <= S_OVER;
                        if (r_score > r_hiscore) begin
                            r_hiscore <= r_score;
                            r_new_hi  <= 1'b1;
                        end
                    end else if (r_state == S_PAUSED) begin
                        if (!pause)
                            r_state <= S_RUN;
                    end else if (pause) begin
                        r_state <= S_PAUSED;
                    end else begin
                        r_div <= w_tick ? '0 : r_div + DW'(1);
                        if (w_carry_out) begin
                            r_score <= ALL_NINES;
                            r_ovf   <= 1'b1;
                        end else begin
                            r_score <= w_sum;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign score_bcd   = r_score;
    assign hiscore_bcd = r_hiscore;
    assign running     = (r_state == S_RUN);
    assign new_hiscore = r_new_hi;
    assign overflow    = r_ovf;

    function automatic logic [6:0] f_seg(input logic [3:0] d);
        case (d)
            4'd0:    f_seg = 7'b1000000;
            4'd1:    f_seg = 7'b1111001;
            4'd2:    f_seg = 7'b0100100;
            4'd3:    f_seg = 7'b0110000;
            4'd4:    f_seg = 7'b0011001;
            4'd5:    f_seg = 7'b0010010;
            4'd6:    f_seg = 7'b0000010;
            4'd7:    f_seg = 7'b1111000;
            4'd8:    f_seg = 7'b0000000;
            4'd9:    f_seg = 7'b0011000;
            default: f_seg = 7'b1111111;
        endcase
    endfunction

    logic [4*DIGITS-1:0] w_disp;
    logic                w_upper_zero;

    // Walk from the top digit down so a digit blanks only when everything above it is zero.
    always_comb begin
        w_disp       = show_hi ? r_hiscore : r_score;
        seg          = '1;
        w_upper_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            w_upper_zero = w_upper_zero && (w_disp[4*i +: 4] == 4'd0);
            if ((BLANK_LZ != 0) && (i > 0) && w_upper_zero)
                seg[7*i +: 7] = 7'b1111111;
            else
                seg[7*i +: 7] = f_seg(w_disp[4*i +: 4]);
        end
    end
endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper with DIGITS=3, TICK_DIV=4, BLANK_LZ=1.
module tb_score_keeper;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        gameover = 1'b0;
    logic        pause = 1'b0;
    logic        bonus_valid = 1'b0;
    logic [3:0]  bonus_amt = 4'd0;
    logic        show_hi = 1'b0;
    logic [11:0] score_bcd;
    logic [11:0] hiscore_bcd;
    logic        running;
    logic        new_hiscore;
    logic        overflow;
    logic [20:0] seg;

    int n_checks = 0;
    int n_fail   = 0;

    score_keeper #(.DIGITS(3), .TICK_DIV(4), .BLANK_LZ(1)) dut (
        .clk(clk), .reset(reset), .start(start), .gameover(gameover),
        .pause(pause), .bonus_valid(bonus_valid), .bonus_amt(bonus_amt),
        .show_hi(show_hi), .score_bcd(score_bcd), .hiscore_bcd(hiscore_bcd),
        .running(running), .new_hiscore(new_hiscore), .overflow(overflow),
        .seg(seg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1; step(1); start = 1'b0;
    endtask

    task automatic pulse_gameover();
        gameover = 1'b1; step(1); gameover = 1'b0;
    endtask

    task automatic bonus(input int amt);
        bonus_valid = 1'b1; bonus_amt = 4'(amt); step(1); bonus_valid = 1'b0;
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_score", 32'(score_bcd), 32'h000);
        check("rst_hi", 32'(hiscore_bcd), 32'h000);
        check("rst_run", 32'(running), 32'd0);
        check("rst_newhi", 32'(new_hiscore), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_seg", 32'(seg), 32'(21'b1111111_1111111_1000000));
        reset = 1'b1;

        // Tick every 4 clocks: 40 cycles -> 10 points
        pulse_start();
        check("run_after_start", 32'(running), 32'd1);
        step(39);
        check("cnt_39", 32'(score_bcd), 32'h009);
        step(1);
        check("cnt_40", 32'(score_bcd), 32'h010);
        check("cnt_running", 32'(running), 32'd1);

        // Pause mid-count with divider at 2; bonus must be ignored
        step(2);
        pause = 1'b1; bonus_valid = 1'b1; bonus_amt = 4'd5;
        step(10);
        check("pause_run", 32'(running), 32'd0);
        check("pause_hold", 32'(score_bcd), 32'h010);
        pause = 1'b0; bonus_valid = 1'b0;
        step(1);
        check("resume_0", 32'(score_bcd), 32'h010);
        step(1);
        check("resume_1", 32'(score_bcd), 32'h010);
        step(1);
        check("resume_tick", 32'(score_bcd), 32'h011);

        // Game 1 ends at 0x012, gameover coincident with a tick
        bonus(1);
        check("bonus_lat", 32'(score_bcd), 32'h012);
        step(2);
        pulse_gameover();
        check("g1_score", 32'(score_bcd), 32'h012);
        check("g1_hi", 32'(hiscore_bcd), 32'h012);
        check("g1_newhi", 32'(new_hiscore), 32'd1);
        check("g1_run", 32'(running), 32'd0);

        // Game 2 ties at 0x012
        pulse_start();
        check("g2_newhi_clr", 32'(new_hiscore), 32'd0);
        bonus(12);
        pulse_gameover();
        check("g2_hi", 32'(hiscore_bcd), 32'h012);
        check("g2_newhi", 32'(new_hiscore), 32'd0);

        // Game 3 ends at 0x020
        pulse_start();
        bonus(15);
        bonus(5);
        pulse_gameover();
        check("g3_hi", 32'(hiscore_bcd), 32'h020);
        check("g3_newhi", 32'(new_hiscore), 32'd1);

        // Carry chain: edges 1..7 reach 0x099 (edge 4 ticks), edge 8 is tick + 15
        pulse_start();
        for (int k = 0; k < 6; k++) bonus(15);
        bonus(8);
        check("carry_pre", 32'(score_bcd), 32'h099);
        bonus(15);
        check("carry_115", 32'(score_bcd), 32'h115);
        pulse_gameover();
        check("carry_hi", 32'(hiscore_bcd), 32'h115);

        // Saturation: 65 x 15 plus 16 ticks = 991, +4 = 995, +9 saturates
        pulse_start();
        for (int k = 0; k < 65; k++) bonus(15);
        bonus(4);
        check("sat_pre", 32'(score_bcd), 32'h995);
        check("sat_pre_ovf", 32'(overflow), 32'd0);
        bonus(9);
        check("sat_999", 32'(score_bcd), 32'h999);
        check("sat_ovf", 32'(overflow), 32'd1);
        step(4);
        check("sat_hold", 32'(score_bcd), 32'h999);
        check("sat_hold_ovf", 32'(overflow), 32'd1);
        pulse_gameover();
        pulse_start();
        check("sat_clr_score", 32'(score_bcd), 32'h000);
        check("sat_clr_ovf", 32'(overflow), 32'd0);

        // Fresh reset so the high score can be 0x105 for the display check
        #3 reset = 1'b0;
        #1;
        check("rst2_hi", 32'(hiscore_bcd), 32'h000);
        reset = 1'b1;
        pulse_start();
        bonus(15); bonus(15); bonus(15); bonus(14); bonus(15); bonus(15); bonus(15);
        check("disp_pre", 32'(score_bcd), 32'h105);
        pulse_gameover();
        show_hi = 1'b1;
        #1;
        check("seg_hi_105", 32'(seg), 32'(21'b1111001_1000000_0010010));
        pulse_start();
        bonus(7);
        show_hi = 1'b0;
        #1;
        check("seg_007", 32'(seg), 32'(21'b1111111_1111111_1111000));

        // Asynchronous reset mid-RUN, sampled before any clock edge
        #2 reset = 1'b0;
        #1;
        check("arst_score", 32'(score_bcd), 32'h000);
        check("arst_hi", 32'(hiscore_bcd), 32'h000);
        check("arst_run", 32'(running), 32'd0);
        check("arst_seg", 32'(seg), 32'(21'b1111111_1111111_1000000));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
Parametrised game score unit for the running-game top level. It is a fully synchronous, single-clock replacement for the rippled-clock score chain.
- Keeps an N-digit packed-BCD score that advances on a divided time tick and on bonus events.
- Tracks a high score across games and drives active-low 7-segment digits showing either score or high score.
- Controlled by start/pause/gameover from the game FSM.

Parameters:
- DIGITS, 6, number of BCD digits in score and high score (1..8).
- TICK_DIV, 50000000, clk cycles per time point; divider counts 0..TICK_DIV-1 (TICK_DIV >= 2).
- BLANK_LZ, 0, 1 = blank leading zero digits on segment outputs; digit 0 is never blanked.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low; clock clk.
- start  input  1  single-cycle pulse: begin a new game.
- gameover  input  1  single-cycle pulse: end current game.
- pause  input  1  level: freeze scoring while high.
- bonus_valid  input  1  single-cycle: add bonus_amt to score.
- bonus_amt  input  4  binary bonus value 0..15.
- show_hi  input  1  segment source select: 0 = score, 1 = high score.
- score_bcd  output  4*DIGITS  current score, packed BCD, digit 0 in LSBs.
- hiscore_bcd  output  4*DIGITS  best score, packed BCD.
- running  output  1  high in RUN state.
- new_hiscore  output  1  last game set a new high score.
- overflow  output  1  sticky: score saturated this game.
- seg  output  7*DIGITS  active-low segments, digit i at bits [7i+6:7i].

Behaviour:
- Reset (async, reset=0):
  - state=IDLE; divider=0; score=0; hiscore=0.
  - running=0; new_hiscore=0; overflow=0.
  - seg shows 0 on every digit, or blank except digit 0 when BLANK_LZ=1.
- States: IDLE, RUN, PAUSED, OVER.
- IDLE / OVER:
  - start -> RUN at next edge; same edge sets score=0, divider=0, overflow=0, new_hiscore=0.
  - gameover, bonus_valid and pause are ignored.
- RUN:
  - divider increments each cycle.
  - On the edge where divider==TICK_DIV-1: divider<=0 and tick=1 for that edge.
  - Score update at that edge is score + tick + (bonus_valid ? bonus_amt : 0). A coincident tick and bonus add together in one edge.
  - pause=1 -> PAUSED at next edge; that edge performs no divider advance and no score update.
- PAUSED:
  - Divider and score frozen; bonus_valid ignored.
  - pause=0 -> RUN at next edge; the divider resumes from its held value.
- gameover in RUN or PAUSED -> OVER at next edge. Priority gameover > pause > tick/bonus: no score change on that edge.
- High score:
  - On the edge entering OVER, if score > hiscore (unsigned compare of packed BCD), then hiscore<=score and new_hiscore<=1.
  - Equal scores do not set new_hiscore.
  - hiscore is cleared only by reset.
- start is ignored in RUN and PAUSED (no restart mid-game).
- Arithmetic:
  - Digit-serial BCD add with a 0..16 addend: digit 0 takes the addend, and carries propagate through all digits within one cycle.
  - Every digit stays in 0..9 at all times.
- Saturation: if the sum exceeds 10^DIGITS-1, score<=all nines and overflow<=1 on that edge. Further increments hold at all nines.
- Outputs:
  - running is combinational from state, high only in RUN.
  - score_bcd and hiscore_bcd are registered values.
- Segments:
  - Combinational from show_hi ? hiscore : score, using the team hex encoding: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000.
  - Blank digit = 1111111.
  - With BLANK_LZ=1, digit i>0 is blanked when it and all higher digits are 0.
- Latency:
  - Tick effect is visible on score_bcd one edge after divider reaches TICK_DIV-1.
  - Bonus effect is visible the edge after bonus_valid.
- Reset mid-game: immediate return to all reset values, including hiscore.

Test Plan:
- TICK_DIV=4, DIGITS=3: reset, pulse start, run 40 cycles -> score_bcd=0x010; running=1; a tick every 4 clk.
- Carry chain, DIGITS=3, score=0x099: apply tick together with bonus_amt=15 -> 0x115 next edge, all nibbles <=9.
- Saturation: score=0x995, bonus_amt=9 -> 0x999 and overflow=1. Further ticks hold 0x999. Next start clears overflow and score.
- Pause: pause=1 for 10 cycles mid-count -> score and divider frozen, bonus ignored. pause=0 -> the next tick arrives after the remaining divider cycles only.
- High score:
  - Game 1 ends at 0x012 -> hiscore=0x012, new_hiscore=1.
  - Game 2 ends at 0x012 -> hiscore unchanged, new_hiscore=0.
  - Game 3 ends at 0x020 -> hiscore=0x020, new_hiscore=1.
  - gameover coincident with a tick leaves the score unchanged.
- Display, BLANK_LZ=1, DIGITS=3:
  - score=0x007 -> seg = {1111111, 1111111, 1111000}.
  - show_hi=1 with hiscore=0x105 -> {1111001, 1000000, 0010010}.
  - Async reset asserted mid-RUN clears all outputs without a clock edge.
